// File: rtl/approx_pipe_adder_if.sv
// ---------------------------------------------------------------------------
// approx_pipe_adder_if
//   Operand/result handshake bundle for approx_pipe_adder.
//   master: the side that supplies operands and consumes results.
//   slave : the adder itself.
// ---------------------------------------------------------------------------
interface approx_pipe_adder_if #(
  parameter int WIDTH = 8
);
  // Operand side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;

  // Result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/approx_pipe_adder.sv
// ---------------------------------------------------------------------------
// approx_pipe_adder
//   Two-stage pipelined adder/subtractor with an approximate low section.
//   The lowest APPROX_BITS result bits are a[i] | b'[i] with no carry chain;
//   the carry into the first exact bit is a[K-1] & b'[K-1] (or the real
//   carry-in when APPROX_BITS = 0). Everything above is an exact ripple add.
//
//   Stage 1 produces the low half of the result and its carry-out; stage 2
//   adds the upper operand halves with that carry. Valid/ready flow control
//   lets both stages advance in the same cycle, so one result per cycle is
//   sustained while out_ready is high.
//
//   Parameters:
//     WIDTH       operand/result width, even, 4..32
//     APPROX_BITS approximate LSB count, 0..WIDTH/2 (0 = exact adder)
//
//   Build option:
//     APPROX_ADDER_SAT_EN  when defined, results saturate (unsigned): an add
//                          that carries out gives all ones, a subtract that
//                          borrows gives zero. cout/ovf stay raw.
// ---------------------------------------------------------------------------
module approx_pipe_adder #(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  approx_pipe_adder_if.slave  bus,
  output logic [15:0]         txn_count
);

  localparam int HALF = WIDTH / 2;

  // -------------------------------------------------------------------------
  // Flow control
  // -------------------------------------------------------------------------
  logic v1;
  logic v2;
  logic adv1;
  logic adv2;

  // Stage 2 frees up when empty or its result is being taken; stage 1 frees
  // up when empty or it can hand its contents to stage 2 this cycle.
  assign adv2         = !v2 || bus.out_ready;
  assign adv1         = !v1 || adv2;
  assign bus.in_ready = adv1;
  assign bus.out_valid = v2;

  // -------------------------------------------------------------------------
  // Operand conditioning
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Subtraction is a + ~b + 1; carry-in is only meaningful for an add.
  always_comb begin
    b_eff = bus.sub ? ~bus.b : bus.b;
    c0    = bus.sub ? 1'b1 : bus.cin;
  end

  // -------------------------------------------------------------------------
  // Stage 1 combinational: low half with approximate LSBs
  // -------------------------------------------------------------------------
  logic [HALF-1:0] lo_sum_d;
  logic            lo_carry_d;

  // Walk the low half: OR-only bits below APPROX_BITS, ripple-carry above.
  always_comb begin
    logic carry;
    // NOTE: every output gets a default before the loop, so no path leaves
    // a variable unassigned and no latch is inferred; 'carry' is updated with
    // blocking assignments because each bit must see the previous bit's value.
    lo_sum_d   = '0;
    lo_carry_d = 1'b0;
    carry      = c0;
    for (int i = 0; i < HALF; i++) begin
      if (i < APPROX_BITS) begin
        lo_sum_d[i] = bus.a[i] | b_eff[i];
        // Only the top approximate bit generates the carry into the exact part.
        if (i == APPROX_BITS - 1) begin
          carry = bus.a[i] & b_eff[i];
        end
      end else begin
        lo_sum_d[i] = bus.a[i] ^ b_eff[i] ^ carry;
        carry       = (bus.a[i] & b_eff[i]) | (carry & (bus.a[i] ^ b_eff[i]));
      end
    end
    lo_carry_d = carry;
  end

  // -------------------------------------------------------------------------
  // Stage 1 registers
  // -------------------------------------------------------------------------
  logic [HALF-1:0] lo_sum_q;
  logic            lo_carry_q;
  logic [HALF-1:0] a_hi_q;
  logic [HALF-1:0] bp_hi_q;
`ifdef APPROX_ADDER_SAT_EN
  logic            sub_q;
`endif

  // Stage 1 occupancy: loads on every advance, so an empty input clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      v1 <= 1'b0;
    end else if (adv1) begin
      v1 <= bus.in_valid;
    end
  end

  // Stage 1 payload: captured only on an input handshake.
  always_ff @(posedge clk) begin
    // NOTE: payload flops carry no reset; the valid bit alone says whether
    // their contents mean anything, and in-flight data is simply discarded.
    if (bus.in_valid && adv1) begin
      lo_sum_q   <= lo_sum_d;
      lo_carry_q <= lo_carry_d;
      a_hi_q     <= bus.a[WIDTH-1:HALF];
      bp_hi_q    <= b_eff[WIDTH-1:HALF];
`ifdef APPROX_ADDER_SAT_EN
      sub_q      <= bus.sub;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2 combinational: upper half, flags, optional saturation
  // -------------------------------------------------------------------------
  logic [HALF:0]    hi_add;
  logic             msb_cin;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;

  // Finish the add and derive raw carry-out and signed overflow.
  always_comb begin
    hi_add  = {1'b0, a_hi_q} + {1'b0, bp_hi_q} + {{HALF{1'b0}}, lo_carry_q};
    // The carry into the MSB is recoverable from the MSB sum bit itself.
    msb_cin = a_hi_q[HALF-1] ^ bp_hi_q[HALF-1] ^ hi_add[HALF-1];
    sum_d   = {hi_add[HALF-1:0], lo_sum_q};
    cout_d  = hi_add[HALF];
    ovf_d   = msb_cin ^ cout_d;
`ifdef APPROX_ADDER_SAT_EN
    if (!sub_q && cout_d) begin
      sum_d = '1;
    end else if (sub_q && !cout_d) begin
      sum_d = '0;
    end
`endif
  end

  // -------------------------------------------------------------------------
  // Stage 2 registers (the visible result)
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  // Result register: holds while stalled, takes stage 1 whenever it advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2     <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

  // -------------------------------------------------------------------------
  // Output handshake counter
  // -------------------------------------------------------------------------

  // Count completed output handshakes; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count <= '0;
    end else if (v2 && bus.out_ready) begin
      txn_count <= txn_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_approx_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_approx_pipe_adder
//   Drives two adders side by side from identical stimulus: one exact
//   (APPROX_BITS=0) and one with a single approximate LSB (APPROX_BITS=1).
//   A per-cycle checker compares both against an arithmetic model fed from
//   a queue of accepted operand sets; directed steps add literal checks.
// ---------------------------------------------------------------------------
module tb_approx_pipe_adder;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] txn0;
  logic [15:0] txn1;

  approx_pipe_adder_if #(.WIDTH(W)) bus0 ();
  approx_pipe_adder_if #(.WIDTH(W)) bus1 ();

  approx_pipe_adder #(.WIDTH(W), .APPROX_BITS(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus0),
    .txn_count (txn0)
  );

  approx_pipe_adder #(.WIDTH(W), .APPROX_BITS(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus1),
    .txn_count (txn1)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] exp_txn0 = '0;
  logic [15:0] exp_txn1 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Arithmetic model: whole-word integer add of the shifted exact part,
  // OR of the approximate part, overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub, input int k);
    exp_t         r;
    logic [W-1:0] bq;
    int           ai, bp, c, upper, raw, s;
    bq    = sub ? ~b : b;
    ai    = int'(a);
    bp    = int'(bq);
    c     = sub ? 1 : int'(cin);
    if (k > 0) c = ((ai & bp) >> (k - 1)) & 1;
    upper = (ai >> k) + (bp >> k) + c;
    raw   = (upper << k) | ((ai | bp) & ((1 << k) - 1));
    s     = raw & 255;
    r.cout = ((raw >> 8) & 1) == 1;
    r.ovf  = (a[7] == bq[7]) && (((s >> 7) & 1) != int'(a[7]));
`ifdef APPROX_ADDER_SAT_EN
    if (!sub && r.cout) s = 255;
    else if (sub && !r.cout) s = 0;
`endif
    r.sum = 8'(s);
    return r;
  endfunction

  // Per-cycle checker: results against the queued model, counter, pushes.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      exp_txn0 = '0;
      exp_txn1 = '0;
      check("rst_out_valid0", bus0.out_valid, 0);
      check("rst_out_valid1", bus1.out_valid, 0);
      check("rst_txn0", txn0, 0);
      check("rst_txn1", txn1, 0);
    end else begin
      check("txn0", txn0, exp_txn0);
      check("txn1", txn1, exp_txn1);
      if (bus0.out_valid) begin
        if (q0.size() == 0) begin
          check("spurious0", bus0.out_valid, 0);
        end else begin
          check("sum0", bus0.sum, q0[0].sum);
          check("cout0", bus0.cout, q0[0].cout);
          check("ovf0", bus0.ovf, q0[0].ovf);
          if (bus0.out_ready) begin
            void'(q0.pop_front());
            exp_txn0++;
          end
        end
      end
      if (bus1.out_valid) begin
        if (q1.size() == 0) begin
          check("spurious1", bus1.out_valid, 0);
        end else begin
          check("sum1", bus1.sum, q1[0].sum);
          check("cout1", bus1.cout, q1[0].cout);
          check("ovf1", bus1.ovf, q1[0].ovf);
          if (bus1.out_ready) begin
            void'(q1.pop_front());
            exp_txn1++;
          end
        end
      end
      if (bus0.in_valid && bus0.in_ready)
        q0.push_back(model(bus0.a, bus0.b, bus0.cin, bus0.sub, 0));
      if (bus1.in_valid && bus1.in_ready)
        q1.push_back(model(bus1.a, bus1.b, bus1.cin, bus1.sub, 1));
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc, input logic ts);
    bus0.in_valid = v; bus0.a = ta; bus0.b = tb; bus0.cin = tc; bus0.sub = ts;
    bus1.in_valid = v; bus1.a = ta; bus1.b = tb; bus1.cin = tc; bus1.sub = ts;
  endtask

  task automatic set_ready(input logic r);
    bus0.out_ready = r;
    bus1.out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set until accepted (bounded), then go idle.
  task automatic push(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tc, input logic ts);
    bit done;
    done = 0;
    drive(1'b1, ta, tb, tc, ts);
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (bus0.in_ready) done = 1;
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("push_accepted", 32'(done), 1);
  endtask

  // Push, confirm no result one cycle after acceptance, then land on the
  // cycle where the result must be visible.
  task automatic one_shot(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic ts);
    push(ta, tb, tc, ts);
    check("lat_not_early", bus0.out_valid, 0);
    tick();
    check("lat_valid0", bus0.out_valid, 1);
    check("lat_valid1", bus1.out_valid, 1);
  endtask

  exp_t        e;
  logic [15:0] base;

  initial begin
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    set_ready(1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_in_ready0", bus0.in_ready, 1);
    check("rst_in_ready1", bus1.in_ready, 1);
    repeat (2) tick();
    rst_n = 1'b1;
    set_ready(1'b1);

    // Pin the model to hand-computed values.
    e = model(8'h0F, 8'h01, 1'b0, 1'b0, 1);
    check("pin_0f_01_k1_sum", e.sum, 8'h11);
    check("pin_0f_01_k1_cout", e.cout, 0);
    e = model(8'h7F, 8'h01, 1'b0, 1'b0, 0);
    check("pin_7f_01_k0_sum", e.sum, 8'h80);
    check("pin_7f_01_k0_ovf", e.ovf, 1);
    e = model(8'h10, 8'h20, 1'b1, 1'b0, 1);
    check("pin_cin_ignored_k1", e.sum, 8'h30);
    e = model(8'h05, 8'h07, 1'b0, 1'b1, 0);
`ifdef APPROX_ADDER_SAT_EN
    check("pin_05_07_sub_k0", e.sum, 8'h00);
`else
    check("pin_05_07_sub_k0", e.sum, 8'hFE);
`endif

    // Approximate LSB: 0x0F + 0x01 with K=1 -> 0x11.
    one_shot(8'h0F, 8'h01, 1'b0, 1'b0);
    check("k1_0f_01_sum", bus1.sum, 8'h11);
    check("k1_0f_01_cout", bus1.cout, 0);
    check("k1_0f_01_ovf", bus1.ovf, 0);
    check("k0_0f_01_sum", bus0.sum, 8'h10);

    // Exact wrap with carry-out.
    one_shot(8'hFF, 8'h01, 1'b0, 1'b0);
`ifdef APPROX_ADDER_SAT_EN
    check("k0_ff_01_sum", bus0.sum, 8'hFF);
`else
    check("k0_ff_01_sum", bus0.sum, 8'h00);
`endif
    check("k0_ff_01_cout", bus0.cout, 1);
    check("k0_ff_01_ovf", bus0.ovf, 0);

    // Subtract with borrow.
    one_shot(8'h05, 8'h07, 1'b0, 1'b1);
`ifdef APPROX_ADDER_SAT_EN
    check("k0_05_07_sub_sum", bus0.sum, 8'h00);
`else
    check("k0_05_07_sub_sum", bus0.sum, 8'hFE);
`endif
    check("k0_05_07_sub_cout", bus0.cout, 0);
    check("k0_05_07_sub_ovf", bus0.ovf, 0);

    // Signed overflow.
    one_shot(8'h7F, 8'h01, 1'b0, 1'b0);
    check("k0_7f_01_sum", bus0.sum, 8'h80);
    check("k0_7f_01_ovf", bus0.ovf, 1);
    check("k0_7f_01_cout", bus0.cout, 0);

    // Carry-in honoured only by the exact adder.
    one_shot(8'h10, 8'h20, 1'b1, 1'b0);
    check("k0_cin_sum", bus0.sum, 8'h31);
    check("k1_cin_sum", bus1.sum, 8'h30);
    repeat (2) tick();

    // Backpressure: two sets fill the pipe, the third waits.
    set_ready(1'b0);
    base = exp_txn0;
    push(8'h11, 8'h22, 1'b0, 1'b0);
    push(8'h33, 8'h44, 1'b1, 1'b0);
    drive(1'b1, 8'h90, 8'h0A, 1'b0, 1'b1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("bp_in_ready0", bus0.in_ready, 0);
      check("bp_in_ready1", bus1.in_ready, 0);
      check("bp_out_valid", bus0.out_valid, 1);
      check("bp_held_sum0", bus0.sum, 8'h33);
      tick();
    end
    set_ready(1'b1);
    push(8'h90, 8'h0A, 1'b0, 1'b1);
    repeat (4) tick();
    check("bp_drain_count", txn0, base + 16'd3);
    check("bp_queue_empty", 32'(q0.size()), 0);

    // Reset with both stages occupied.
    set_ready(1'b0);
    push(8'hA5, 8'h5A, 1'b0, 1'b0);
    push(8'h3C, 8'hC3, 1'b0, 1'b1);
    check("pre_rst_out_valid", bus0.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid0", bus0.out_valid, 0);
    check("mid_rst_out_valid1", bus1.out_valid, 0);
    check("mid_rst_txn0", txn0, 0);
    check("mid_rst_in_ready", bus0.in_ready, 1);
    tick();
    rst_n = 1'b1;
    set_ready(1'b1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("post_rst_no_out0", bus0.out_valid, 0);
      check("post_rst_no_out1", bus1.out_valid, 0);
      tick();
    end

    // Counter wrap: 65537 back-to-back handshakes from a fresh reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 65537; n++) begin
      drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (4) tick();
    check("wrap_txn0", txn0, 16'h0001);
    check("wrap_txn1", txn1, 16'h0001);
    check("wrap_queue_empty0", 32'(q0.size()), 0);
    check("wrap_queue_empty1", 32'(q1.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/approx_pipe_adder.md
APPROX_PIPE_ADDER -- requirements
Module: approx_pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; even, range 4..32.
REQ-002 SHALL have parameter APPROX_BITS, default 1, number of approximate LSBs; range 0..WIDTH/2; 0 = exact adder.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand set present.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 a  input  WIDTH  operand A (unsigned, or two's complement for ovf).
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in, used only when sub=0 and APPROX_BITS=0.
REQ-011 sub  input  1  0 = a+b+cin; 1 = a+~b+1.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 sum  output  WIDTH  result.
REQ-015 cout  output  1  raw carry-out of MSB (sub: 1 = no borrow).
REQ-016 ovf  output  1  signed overflow (carry into MSB XOR cout).
REQ-017 txn_count  output  16  number of output handshakes since reset.

Function
REQ-018 SHALL form b' = sub ? ~b : b; exact carry-in c0 = sub ? 1 : cin.
REQ-019 SHALL compute bits i < APPROX_BITS as sum[i] = a[i] | b'[i], no carry propagation (c0 ignored).
REQ-020 SHALL feed carry a[K-1] & b'[K-1] into bit K=APPROX_BITS when K>0; when K=0, c0.
REQ-021 SHALL compute bits K..WIDTH-1 as an exact ripple-carry add.
REQ-022 SHALL pipeline in 2 stages: stage 1 registers low half [WIDTH/2-1:0], its carry-out, and the upper operand halves; stage 2 adds upper half with the registered carry.
REQ-023 SHALL give latency 2 cycles from input handshake to out_valid with no stall.
REQ-024 Input handshake = in_valid & in_ready; output handshake = out_valid & out_ready.
REQ-025 Stage 2 advances when !v2 | out_ready; stage 1 advances when !v1 | stage-2 advance; in_ready = !v1 | stage-2 advance (combinational from out_ready).
REQ-026 SHALL hold sum/cout/ovf/out_valid stable while out_valid & !out_ready.
REQ-027 SHALL sustain one result per cycle with out_ready held high; results in input order, none dropped or duplicated.
REQ-028 txn_count SHALL increment by 1 per output handshake, wrapping 0xFFFF -> 0x0000.
REQ-029 Simultaneous input and output handshake SHALL both complete in the same cycle.

Reset
REQ-030 rst_n low SHALL immediately clear v1, v2, out_valid, sum, cout, ovf, txn_count to 0, including mid-operation; in-flight operands are discarded.
REQ-031 in_ready SHALL read 1 during and after reset (pipe empty).

Configuration
REQ-032 Macro APPROX_ADDER_SAT_EN defined: unsigned saturation -- add with cout=1 gives sum = all ones; sub with cout=0 gives sum = 0; cout/ovf still raw.
REQ-033 Macro undefined: sum wraps modulo 2^WIDTH; no saturation logic.

Verification (WIDTH=8)
REQ-034 APPROX_BITS=1, a=0x0F, b=0x01, sub=0, cin=0 -> 2 cycles later out_valid=1, sum=0x11, cout=0, ovf=0.
REQ-035 APPROX_BITS=0, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (SAT_EN: sum=0xFF, cout=1).
REQ-036 APPROX_BITS=0, a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0 (SAT_EN: sum=0x00); a=0x7F, b=0x01, sub=0 -> sum=0x80, ovf=1.
REQ-037 out_ready=0, push 3 sets back-to-back -> 2 accepted, in_ready=0 on third, out held; out_ready=1 -> drain in order, third accepted, no loss.
REQ-038 rst_n pulsed low with both stages valid -> out_valid=0 and txn_count=0 same cycle, no result emitted after release.
REQ-039 65537 handshakes with out_ready=1 -> txn_count=0x0001.
